// File: rtl/lit_pkg.sv
// Shared definitions for the literal-token writer.
// Token word layout (MSB first): {len, addr, data}. The *_DEF constants describe
// the default geometry; modules derive their own field positions from their
// parameters so that non-default builds stay consistent.
package lit_pkg;

  localparam int DATA_BYTES_DEF = 8;
  localparam int ADDR_W_DEF     = 16;
  localparam int LEN_W_DEF      = 4;
  localparam int LINE_BYTES_DEF = 8;

  localparam int LINE_SHIFT     = $clog2(LINE_BYTES_DEF);

  localparam int TOK_DATA_LSB   = 0;
  localparam int TOK_DATA_W     = DATA_BYTES_DEF * 8;
  localparam int TOK_ADDR_LSB   = TOK_DATA_LSB + TOK_DATA_W;
  localparam int TOK_ADDR_W     = ADDR_W_DEF;
  localparam int TOK_LEN_LSB    = TOK_ADDR_LSB + TOK_ADDR_W;
  localparam int TOK_LEN_W      = LEN_W_DEF;
  localparam int TOK_W_DEF      = TOK_LEN_LSB + TOK_LEN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } lit_state_t;

endpackage

// File: rtl/lit_line_align.sv
// Combinational line alignment of one literal token.
// Ports:
//   addr, len, data : token fields
//   line            : history line of the first byte
//   data_rot        : data zero-extended to a line and rotated left by the
//                     in-line byte offset, so every byte sits on its own lane
//   be1, be2        : byte enables of the first and (optional) second beat
//   split           : token spills into the next line
//   none            : token carries no bytes
module lit_line_align
  import lit_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [LEN_W-1:0]                     len,
  input  logic [DATA_BYTES*8-1:0]              data,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] line,
  output logic [LINE_BYTES*8-1:0]              data_rot,
  output logic [LINE_BYTES-1:0]                be1,
  output logic [LINE_BYTES-1:0]                be2,
  output logic                                 split,
  output logic                                 none
);

  localparam int LSH = $clog2(LINE_BYTES);
  localparam int LW  = LINE_BYTES * 8;

  int                off;
  int                len_eff;
  int                n1;
  int                n2;
  logic [LW-1:0]     ext;
  logic [2*LW-1:0]   dbl;

  assign line = addr[ADDR_W-1:LSH];

  always_comb begin
    off     = int'(addr[LSH-1:0]);
    // Lengths beyond the carried data enable nothing extra.
    len_eff = (int'(len) > DATA_BYTES) ? DATA_BYTES : int'(len);
    n1      = (len_eff < (LINE_BYTES - off)) ? len_eff : (LINE_BYTES - off);
    n2      = len_eff - n1;
    ext     = '0;
    ext[DATA_BYTES*8-1:0] = data;
    // Upper half of a doubled word shifted left is the rotate-left.
    dbl      = {ext, ext} << (off * 8);
    data_rot = dbl[2*LW-1 -: LW];
    be1      = '0;
    be2      = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      be1[i] = (i >= off) && (i < off + n1);
      be2[i] = (i < n2);
    end
    split = (n2 != 0);
    none  = (len_eff == 0);
  end

endmodule

// File: rtl/lit_token_writer.sv
// Literal-token writer: pops {len, addr, data} tokens from the parser FIFO
// (read data returns one cycle after fifo_rd_en) into a 2-entry skid buffer
// and turns each into one or two line-aligned, byte-enabled history writes.
// Ports:
//   clk, srst            : clock, synchronous active-high reset
//   fifo_empty/rd_en/dout: FIFO read port
//   wr_valid/ready       : write handshake; wr_line, wr_data, wr_be beat payload
//   busy                 : token held, in flight, or being written
// Optional build macro LIT_TOKEN_WRITER_STATS_EN adds tok_cnt, beat_cnt,
// split_cnt and stall_cnt (32-bit wrapping event counters).
module lit_token_writer
  import lit_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int TOK_W      = DATA_BYTES*8 + ADDR_W + LEN_W
) (
  input  logic                                 clk,
  input  logic                                 srst,
  input  logic                                 fifo_empty,
  output logic                                 fifo_rd_en,
  input  logic [TOK_W-1:0]                     fifo_dout,
  output logic                                 wr_valid,
  input  logic                                 wr_ready,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] wr_line,
  output logic [LINE_BYTES*8-1:0]              wr_data,
  output logic [LINE_BYTES-1:0]                wr_be,
`ifdef LIT_TOKEN_WRITER_STATS_EN
  output logic [31:0]                          tok_cnt,
  output logic [31:0]                          beat_cnt,
  output logic [31:0]                          split_cnt,
  output logic [31:0]                          stall_cnt,
`endif
  output logic                                 busy
);

  localparam int LINE_W = ADDR_W - $clog2(LINE_BYTES);
  localparam int A_LSB  = DATA_BYTES * 8;
  localparam int L_LSB  = A_LSB + ADDR_W;

  lit_state_t              state_q, state_d;
  logic [1:0]              occ_q;
  logic                    inflight_q;
  logic [TOK_W-1:0]        skid_q [2];
  logic [LINE_BYTES-1:0]   be2_q;
  logic                    split_q;

  logic [TOK_W-1:0]        sel_tok;
  logic [LINE_W-1:0]       aln_line;
  logic [LINE_BYTES*8-1:0] aln_data;
  logic [LINE_BYTES-1:0]   aln_be1, aln_be2;
  logic                    aln_split, aln_none;
  logic                    pop, load, to_beat2;
  logic [1:0]              widx;

  assign wr_valid   = (state_q != IDLE);
  assign busy       = (occ_q != 2'd0) || inflight_q || (state_q != IDLE);
  assign fifo_rd_en = !srst && !fifo_empty && ((occ_q + {1'b0, inflight_q}) < 2'd2);

  // While a token is being written the aligner looks one entry ahead, so the
  // next beat 1 can be loaded on the final handshake with no bubble.
  assign sel_tok = (state_q == IDLE) ? skid_q[0] : skid_q[1];

  lit_line_align #(
    .DATA_BYTES (DATA_BYTES),
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .LINE_BYTES (LINE_BYTES)
  ) u_align (
    .addr     (sel_tok[A_LSB +: ADDR_W]),
    .len      (sel_tok[L_LSB +: LEN_W]),
    .data     (sel_tok[A_LSB-1:0]),
    .line     (aln_line),
    .data_rot (aln_data),
    .be1      (aln_be1),
    .be2      (aln_be2),
    .split    (aln_split),
    .none     (aln_none)
  );

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load     = 1'b0;
    to_beat2 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (occ_q != 2'd0) begin
          if (aln_none) begin
            pop = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = BEAT1;
          end
        end
      end
      BEAT1, BEAT2: begin
        if (wr_ready) begin
          if (state_q == BEAT1 && split_q) begin
            to_beat2 = 1'b1;
            state_d  = BEAT2;
          end else begin
            pop = 1'b1;
            // Zero-length successors are left for IDLE to drop.
            if (occ_q == 2'd2 && !aln_none) begin
              load    = 1'b1;
              state_d = BEAT1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign widx = occ_q - {1'b0, pop};

  // Stage: control registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      occ_q      <= occ_q - {1'b0, pop} + {1'b0, inflight_q};
    end
  end

  // Stage: skid buffer; entry 0 is the head, the returned word lands behind
  // whatever remains after this cycle's pop.
  always_ff @(posedge clk) begin
    if (pop)        skid_q[0]       <= skid_q[1];
    if (inflight_q) skid_q[widx[0]] <= fifo_dout;
  end

  // Stage: output beat registers
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_line <= '0;
      wr_data <= '0;
      wr_be   <= '0;
    end else if (load) begin
      wr_line <= aln_line;
      wr_data <= aln_data;
      wr_be   <= aln_be1;
    end else if (to_beat2) begin
      wr_line <= wr_line + LINE_W'(1);
      wr_be   <= be2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      be2_q   <= aln_be2;
      split_q <= aln_split;
    end
  end

`ifdef LIT_TOKEN_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      tok_cnt   <= '0;
      beat_cnt  <= '0;
      split_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      tok_cnt   <= tok_cnt   + 32'(pop);
      beat_cnt  <= beat_cnt  + 32'(wr_valid && wr_ready);
      split_cnt <= split_cnt + 32'(to_beat2);
      stall_cnt <= stall_cnt + 32'(wr_valid && !wr_ready);
    end
  end
`endif

  len_legal: assert property (@(posedge clk) disable iff (srst)
    inflight_q |-> (int'(fifo_dout[L_LSB +: LEN_W]) <= DATA_BYTES));

endmodule

// File: tb/tb_lit_token_writer.sv
module tb_lit_token_writer;

  localparam int DB  = 8;
  localparam int AW  = 16;
  localparam int LW  = 4;
  localparam int LB  = 8;
  localparam int TW  = DB*8 + AW + LW;
  localparam int LNW = AW - 3;

  logic           clk = 1'b0;
  logic           srst = 1'b1;
  logic           fifo_empty = 1'b1;
  logic           fifo_rd_en;
  logic [TW-1:0]  fifo_dout = '0;
  logic           wr_valid;
  logic           wr_ready = 1'b0;
  logic [LNW-1:0] wr_line;
  logic [63:0]    wr_data;
  logic [7:0]     wr_be;
  logic           busy;
`ifdef LIT_TOKEN_WRITER_STATS_EN
  logic [31:0]    tok_cnt, beat_cnt, split_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  lit_token_writer dut (
    .clk        (clk),
    .srst       (srst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_line    (wr_line),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
`ifdef LIT_TOKEN_WRITER_STATS_EN
    .tok_cnt    (tok_cnt),
    .beat_cnt   (beat_cnt),
    .split_cnt  (split_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .busy       (busy)
  );

  typedef struct packed {
    logic [LNW-1:0] line;
    logic [63:0]    data;
    logic [7:0]     be;
  } beat_t;

  beat_t         exp_q[$];
  logic [TW-1:0] fq[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            hs_cnt  = 0;
  logic          pop_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: each byte goes to the line/lane of its own byte address.
  task automatic push_tok(input logic [15:0] addr, input logic [3:0] len, input logic [63:0] data);
    beat_t       b1, b2;
    logic [15:0] a;
    logic [63:0] rot;
    int          lane;
    fq.push_back({len, addr, data});
    if (len == 4'd0) return;
    rot = '0;
    for (int i = 0; i < DB; i++) begin
      a    = addr + 16'(i);
      lane = int'(a[2:0]);
      rot[lane*8 +: 8] = data[i*8 +: 8];
    end
    b1.line = addr[15:3]; b1.data = rot; b1.be = '0;
    b2.line = '0;         b2.data = rot; b2.be = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 16'(i);
      if (a[15:3] == addr[15:3]) b1.be[a[2:0]] = 1'b1;
      else begin
        b2.be[a[2:0]] = 1'b1;
        b2.line       = a[15:3];
      end
    end
    exp_q.push_back(b1);
    if (b2.be != 8'h00) exp_q.push_back(b2);
  endtask

  // One clock of the FIFO model; returns at the falling edge.
  task automatic step();
    fifo_empty = (fq.size() == 0);
    #1;
    pop_pending = fifo_rd_en;
    @(posedge clk);
    #1;
    if (srst) begin
      fq.delete();
      exp_q.delete();
    end else if (pop_pending) begin
      if (fq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pop_empty: read issued with no token");
      end else begin
        fifo_dout = fq.pop_front();
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && fq.size() == 0 && !busy) break;
      step();
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor.
  initial begin
    beat_t prev;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (srst) begin
        prev_stall = 1'b0;
        hs_cnt     = 0;
      end else begin
        if (prev_stall) begin
          n_tests++;
          if (!wr_valid || wr_line !== prev.line || wr_data !== prev.data || wr_be !== prev.be) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%0b line=%0h be=%0h data=%0h, required v=1 line=%0h be=%0h data=%0h",
                     wr_valid, wr_line, wr_be, wr_data, prev.line, prev.be, prev.data);
          end
        end
        if (fifo_empty) chk("rd_en_when_empty", 64'(fifo_rd_en), 64'd0);
        if (wr_valid && wr_ready) begin
          beat_t e;
          hs_cnt++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got line=%0h be=%0h data=%0h, required no beat",
                     wr_line, wr_be, wr_data);
          end else begin
            e = exp_q.pop_front();
            if (wr_line !== e.line || wr_be !== e.be || wr_data !== e.data) begin
              n_fail++;
              $display("FAIL beat: got line=%0h be=%0h data=%0h, required line=%0h be=%0h data=%0h",
                       wr_line, wr_be, wr_data, e.line, e.be, e.data);
            end
          end
        end
        prev_stall = wr_valid && !wr_ready;
        prev.line  = wr_line;
        prev.data  = wr_data;
        prev.be    = wr_be;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    // Reset values
    srst = 1'b1; wr_ready = 1'b0;
    repeat (3) step();
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_line", 64'(wr_line), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_wr_be", 64'(wr_be), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    srst = 1'b0;
    step();

    // Aligned, straddling and address-wrapping tokens
    wr_ready = 1'b1;
    push_tok(16'h0010, 4'd8, 64'h0807060504030201);
    push_tok(16'h0015, 4'd6, 64'h0807060504030201);
    push_tok(16'hFFFE, 4'd4, 64'h1122334455667788);
    drain();

    // Zero-length token between two valid ones
    push_tok(16'h0123, 4'd3, 64'hA1A2A3A4A5A6A7A8);
    push_tok(16'h0200, 4'd0, 64'hDEADBEEFDEADBEEF);
    push_tok(16'h0207, 4'd5, 64'hB1B2B3B4B5B6B7B8);
    drain();

    // Backpressure with six tokens queued
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      push_tok(16'($urandom), 4'($urandom_range(1, 8)), {$urandom, $urandom});
    repeat (10) step();
    chk("bp_fifo_left", 64'(fq.size()), 64'd4);
    chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_valid", 64'(wr_valid), 64'd1);
    wr_ready = 1'b1;
    drain();

    // Reset during beat 2 with a read in flight
    wr_ready = 1'b0;
    push_tok(16'h0015, 4'd6, 64'h0807060504030201);
    for (k = 0; k < 20; k++) begin
      if (wr_valid) break;
      step();
    end
    chk("rstmid_setup_valid", 64'(wr_valid), 64'd1);
    push_tok(16'h0040, 4'd8, 64'hCAFEF00DCAFEF00D);
    wr_ready = 1'b1;
    step();
    chk("rstmid_beat2_be", 64'(wr_be), 64'h07);
    wr_ready = 1'b0;
    srst = 1'b1;
    step();
    chk("rstmid_wr_valid", 64'(wr_valid), 64'd0);
    chk("rstmid_wr_line", 64'(wr_line), 64'd0);
    chk("rstmid_wr_data", wr_data, 64'd0);
    chk("rstmid_wr_be", 64'(wr_be), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    srst = 1'b0;
    wr_ready = 1'b1;
    repeat (10) begin
      step();
      chk("rstmid_no_stale_busy", 64'(busy), 64'd0);
      chk("rstmid_no_stale_valid", 64'(wr_valid), 64'd0);
    end

    // Randomized traffic
    repeat (1500) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 6)
        push_tok(16'($urandom), 4'($urandom_range(0, 8)), {$urandom, $urandom});
      wr_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    wr_ready = 1'b1;
    drain();

`ifdef LIT_TOKEN_WRITER_STATS_EN
    step();
    chk("stats_beat_cnt", 64'(beat_cnt), 64'(hs_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
